// File: rtl/btn_event_ctrl.sv
// Multi-button input controller: per-button sync + debounce + toggle, with
// pressed-button indices queued through a fixed-priority arbiter into a
// small event FIFO that the CPU drains via valid/ready.

// Per-button lane: two-flop synchronizer, debounce counter and toggle state.
module btn_event_lane #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press,
    output logic toggle
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic          tog_q, tog_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has disagreed with db for
    // DEBOUNCE_CYCLES consecutive samples; a 0->1 acceptance is a press.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        press = 1'b0;
        if (s2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d  = s2_q;
                press = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        tog_d = tog_q ^ press;
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else begin
            s1_q  <= btn;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
            tog_q <= tog_d;
        end
    end

    assign toggle = tog_q;
endmodule

module btn_event_ctrl #(
    parameter int  NUM_BTNS        = 4,
    parameter int  DEBOUNCE_CYCLES = 250000,
    parameter int  FIFO_DEPTH      = 4,
    localparam int IDW             = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn,
    output logic                evt_valid,
    output logic [IDW-1:0]      evt_id,
    input  logic                evt_ready,
    output logic [NUM_BTNS-1:0] toggle_out,
    output logic                overflow,
    input  logic                overflow_clr
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    logic [NUM_BTNS-1:0] press, grant;
    logic [NUM_BTNS-1:0] pend_q, pend_d;
    logic [IDW-1:0]      gnt_id;
    logic                push, pop, ovf_set;
    logic [IDW-1:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                vld_q, vld_d;
    logic [IDW-1:0]      id_q, id_d;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_lane
        btn_event_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn    (btn[g]),
            .press  (press[g]),
            .toggle (toggle_out[g])
        );
    end

    // Arbiter and pending bits: lowest pending index wins the write port
    // when the FIFO has room; a press landing on an ungranted pend is lost.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        if (cnt_q < CNTW'(FIFO_DEPTH)) begin
            for (int i = NUM_BTNS - 1; i >= 0; i--) begin
                if (pend_q[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    gnt_id   = IDW'(i);
                end
            end
        end
        push    = |grant;
        pend_d  = (pend_q & ~grant) | press;
        ovf_set = |(press & pend_q & ~grant);
        ovf_d   = ovf_set | (ovf_q & ~overflow_clr);
    end

    // FIFO bookkeeping; the head is re-registered so evt_id/evt_valid
    // never depend combinationally on evt_ready.
    always_comb begin
        pop  = vld_q & evt_ready;
        wr_d = push ? wr_q + PW'(1) : wr_q;
        rd_d = pop  ? rd_q + PW'(1) : rd_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
        id_d = id_q;
        if (cnt_d != '0) begin
            // Entry being written this cycle is not in mem_q yet.
            id_d = (push && (wr_q == rd_d)) ? gnt_id : mem_q[rd_d];
        end
        vld_d = (cnt_d != '0);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
            id_q   <= '0;
        end else begin
            pend_q <= pend_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
            id_q   <= id_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= gnt_id;
    end

    assign evt_valid = vld_q;
    assign evt_id    = id_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios followed by randomized
// button/ready traffic, checked against a behavioural model plus a
// scoreboard of expected event ids.
module tb_btn_event_ctrl;
    localparam int NB  = 4;
    localparam int DB  = 4;
    localparam int FD  = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NB-1:0]  btn = '0;
    logic           evt_ready = 1'b0;
    logic           overflow_clr = 1'b0;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic [NB-1:0]  toggle_out;
    logic           overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    btn_event_ctrl #(.NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .evt_valid    (evt_valid),
        .evt_id       (evt_id),
        .evt_ready    (evt_ready),
        .toggle_out   (toggle_out),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    // ---------------- reference model ----------------
    bit [NB-1:0] m_s1, m_s2, m_db, m_tog, m_pend;
    int          m_streak [NB];
    int          m_fifo [$];
    int          sb_q [$];
    bit          m_ovf;
    int          m_head;

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_tog = '0; m_pend = '0;
        foreach (m_streak[i]) m_streak[i] = 0;
        m_fifo.delete();
        sb_q.delete();
        m_ovf  = 1'b0;
        m_head = 0;
    endfunction

    // One clock edge of the spec's behaviour, using the inputs present at the edge.
    function automatic void model_step();
        bit [NB-1:0] pressed;
        int          gid;
        bit          ovf_set;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pressed = '0;
        // A level is accepted after DB consecutive synchronized samples disagree with it.
        for (int i = 0; i < NB; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_streak[i] = m_streak[i] + 1;
                if (m_streak[i] == DB) begin
                    m_db[i]     = m_s2[i];
                    m_streak[i] = 0;
                    pressed[i]  = m_s2[i];
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
        // Lowest pending index gets the slot if the queue had room before this edge.
        gid = -1;
        if (m_fifo.size() < FD)
            for (int i = 0; i < NB; i++)
                if (m_pend[i] && gid < 0) gid = i;
        if (m_fifo.size() > 0 && evt_ready) void'(m_fifo.pop_front());
        ovf_set = 1'b0;
        for (int i = 0; i < NB; i++)
            if (pressed[i] && m_pend[i] && gid != i) ovf_set = 1'b1;
        if (gid >= 0) begin
            m_fifo.push_back(gid);
            sb_q.push_back(gid);
            m_pend[gid] = 1'b0;
        end
        m_pend = m_pend | pressed;
        m_tog  = m_tog ^ pressed;
        if (ovf_set) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
        if (m_fifo.size() > 0) m_head = m_fifo[0];
    endfunction

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("evt_valid", 32'(evt_valid), 32'(m_fifo.size() != 0));
            check("evt_id",    32'(evt_id),    32'(m_head));
            check("toggle",    32'(toggle_out), 32'(m_tog));
            check("overflow",  32'(overflow),  32'(m_ovf));
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL evt_pop: actual %0h required <no event> at %0t", evt_id, $time);
                end else begin
                    check("evt_pop", 32'(evt_id), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values with all buttons held, then one press each after release.
        btn = 4'b1111;
        cyc(3);
        check("rst_valid",  32'(evt_valid),  32'(0));
        check("rst_id",     32'(evt_id),     32'(0));
        check("rst_toggle", 32'(toggle_out), 32'(0));
        check("rst_ovf",    32'(overflow),   32'(0));
        rst_n = 1'b1;
        cyc(6);
        check("held_toggle", 32'(toggle_out), 32'(4'b1111));
        btn = '0;
        cyc(8);
        evt_ready = 1'b1;
        cyc(6);
        evt_ready = 1'b0;
        check("held_drained", 32'(evt_valid), 32'(0));

        // Clean press on button 2.
        do_reset();
        cyc(1);
        btn[2] = 1'b1;
        cyc(5);
        check("clean_tog_early", 32'(toggle_out), 32'(0));
        cyc(1);
        check("clean_tog", 32'(toggle_out), 32'(4'b0100));
        check("clean_vld_early", 32'(evt_valid), 32'(0));
        cyc(1);
        check("clean_vld", 32'(evt_valid), 32'(1));
        check("clean_id",  32'(evt_id),    32'(2));
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        check("clean_popped", 32'(evt_valid), 32'(0));
        btn[2] = 1'b0;
        cyc(10);
        check("release_no_evt", 32'(evt_valid), 32'(0));
        check("release_tog",    32'(toggle_out), 32'(4'b0100));

        // Bounce on button 0: short high burst must not count.
        do_reset();
        cyc(1);
        btn[0] = 1'b1; cyc(3);
        btn[0] = 1'b0; cyc(1);
        btn[0] = 1'b1; cyc(5);
        check("bounce_tog_early", 32'(toggle_out[0]), 32'(0));
        cyc(1);
        check("bounce_tog", 32'(toggle_out[0]), 32'(1));
        cyc(4);
        btn[0] = 1'b0;
        evt_ready = 1'b1;
        cyc(8);
        evt_ready = 1'b0;
        check("bounce_drained", 32'(evt_valid), 32'(0));

        // Simultaneous presses on 3 and 1 drain in ascending order.
        do_reset();
        evt_ready = 1'b1;
        btn = 4'b1010;
        cyc(7);
        check("simul_vld0", 32'(evt_valid), 32'(1));
        check("simul_id0",  32'(evt_id),    32'(1));
        cyc(1);
        check("simul_vld1", 32'(evt_valid), 32'(1));
        check("simul_id1",  32'(evt_id),    32'(3));
        cyc(1);
        check("simul_empty", 32'(evt_valid), 32'(0));
        check("simul_tog",   32'(toggle_out), 32'(4'b1010));
        btn = '0;
        cyc(8);
        evt_ready = 1'b0;

        // Overflow: fill FIFO, one coalesced pending press, then a lost press.
        do_reset();
        btn = 4'b1111; cyc(8);
        btn = '0;      cyc(8);
        check("ovf_full_vld", 32'(evt_valid), 32'(1));
        btn[0] = 1'b1; cyc(8);
        check("ovf_pend_only", 32'(overflow),   32'(0));
        check("ovf_tog1",      32'(toggle_out), 32'(4'b1110));
        btn[0] = 1'b0; cyc(8);
        btn[0] = 1'b1; cyc(8);
        check("ovf_set", 32'(overflow),   32'(1));
        check("ovf_tog2", 32'(toggle_out), 32'(4'b1111));
        btn[0] = 1'b0;
        overflow_clr = 1'b1;
        cyc(1);
        overflow_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'(0));
        evt_ready = 1'b1;
        cyc(8);
        evt_ready = 1'b0;
        check("ovf_drained", 32'(evt_valid), 32'(0));

        // Reset mid-operation: queued entries and a half-debounced press vanish.
        do_reset();
        btn = 4'b0101; cyc(9);
        btn = '0;      cyc(8);
        check("midrst_queued", 32'(evt_valid), 32'(1));
        btn[1] = 1'b1; cyc(4);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_vld", 32'(evt_valid),  32'(0));
        check("midrst_id",  32'(evt_id),     32'(0));
        check("midrst_tog", 32'(toggle_out), 32'(0));
        btn[1] = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        cyc(12);
        check("midrst_no_stale", 32'(evt_valid), 32'(0));
        evt_ready = 1'b0;

        // Randomized traffic with varying consumer throughput.
        do_reset();
        for (int blk = 0; blk < 20; blk++) begin
            int ready_pct;
            ready_pct = $urandom_range(0, 100);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    int k;
                    k = $urandom_range(0, NB - 1);
                    btn[k] = ~btn[k];
                end
                evt_ready    = ($urandom_range(0, 99) < ready_pct);
                overflow_clr = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 999) == 0) do_reset();
                cyc(1);
            end
        end
        overflow_clr = 1'b0;
        evt_ready = 1'b1;
        btn = '0;
        cyc(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
